// File: rtl/instr_fetch_unit.sv
// Generic synchronous FIFO with simultaneous push/pop and a synchronous flush.
// Latency: a word pushed in cycle t is visible on head_dat from cycle t+1.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Fetch front end: issues imem requests from fetch_pc and buffers returned words for decode.
// Latency: request accepted in cycle t with 1-cycle memory appears on ir in cycle t+2.
// Backpressure: requests are credit-limited by outstanding + buffered <= FIFO_DEPTH; stall holds ir.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] ir_pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } ibuf_t;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_count;
  logic [CW:0]   credit_used;
  logic [31:0]   tag_pc;
  logic          accept;
  logic          rsp_drop;
  logic          buf_push;
  logic          buf_pop;
  ibuf_t         buf_in;
  ibuf_t         buf_head;

  // Credits cover both in-flight requests (including ones to be dropped) and buffered words,
  // so a returning response always finds room in the instruction buffer.
  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = !reset && !redirect && (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response arriving on a redirect cycle belongs to the old path and is discarded too.
  assign rsp_drop = redirect || (drop_cnt != '0);
  assign buf_push = imem_rsp_valid && !rsp_drop;
  assign buf_pop  = (buf_count != '0) && !stall && !redirect;
  assign buf_in   = '{pc: tag_pc, dat: imem_rsp_data};

  // In-order tag queue: its occupancy is exactly the number of outstanding requests.
  ifu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .push     (accept),
    .push_dat (fetch_pc),
    .pop      (imem_rsp_valid),
    .head_dat (tag_pc),
    .count    (outstanding)
  );

  // Instruction buffer presented to decode; flushed on redirect.
  ifu_fifo #(.WIDTH($bits(ibuf_t)), .DEPTH(FIFO_DEPTH), .CW(CW)) u_ibuf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (buf_push),
    .push_dat (buf_in),
    .pop      (buf_pop),
    .head_dat (buf_head),
    .count    (buf_count)
  );

  // Fetch PC: redirect overrides, otherwise advance by one word per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Count of stale responses still to be discarded after a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assign ir_valid = (buf_count != '0);
  assign ir       = ir_valid ? buf_head.dat : NOP_INSTR;
  assign ir_pc    = ir_valid ? buf_head.pc  : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic against a queue-based model.
// Latency: outputs sampled 1 time unit after inputs change at the falling edge.
// Backpressure: imem ready, memory latency, stall and redirect are all driven by the bench.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] ir_pc;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ir             (ir),
    .ir_valid       (ir_valid),
    .ir_pc          (ir_pc),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int lat = 1;
  bit have_state = 1'b0;

  // Reference model: fetch pc, memory in-flight queue (= outstanding), decode buffer, drop count.
  logic [31:0] m_pc;
  int          m_drop;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] bq_pc[$];
  logic [31:0] bq_dat[$];

  bit          c_rst, c_stall, c_redir, c_rdy, c_rsp, e_rv;
  logic [31:0] c_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0070_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then compare outputs with the model.
  task automatic drive(input bit rst, input bit stl, input bit rdr,
                       input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    c_rst = rst; c_stall = stl; c_redir = rdr; c_rpc = rpc; c_rdy = rdy;
    c_rsp = !rst && (mq_addr.size() > 0) && (mq_due.size() > 0) && (mq_due[0] <= cyc);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc; imem_req_ready = rdy;
    imem_rsp_valid = c_rsp;
    imem_rsp_data  = c_rsp ? mem_word(mq_addr[0]) : $urandom;
    #1;
    e_rv = !rst && !rdr && ((mq_addr.size() + bq_pc.size()) < DEPTH);
    if (have_state) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
      chk("req_addr", imem_req_addr, m_pc);
      chk("ir_valid", {31'b0, ir_valid}, (bq_pc.size() > 0) ? 32'h1 : 32'h0);
      chk("ir", ir, (bq_pc.size() > 0) ? bq_dat[0] : NOP);
      chk("ir_pc", ir_pc, (bq_pc.size() > 0) ? bq_pc[0] : 32'h0);
    end
  endtask

  // Advance the model across the rising edge using the inputs applied this cycle.
  task automatic tick();
    logic [31:0] a;
    int          d;
    @(posedge clk);
    if (c_rst) begin
      m_pc = RESET_PC; m_drop = 0;
      mq_addr.delete(); mq_due.delete(); bq_pc.delete(); bq_dat.delete();
      have_state = 1'b1;
    end else begin
      if (!c_stall && !c_redir && bq_pc.size() > 0) begin
        a = bq_pc.pop_front();
        a = bq_dat.pop_front();
      end
      if (c_rsp) begin
        a = mq_addr.pop_front();
        d = mq_due.pop_front();
        if (c_redir) begin
          // response on the redirect cycle is stale
        end else if (m_drop > 0) begin
          m_drop--;
        end else begin
          bq_pc.push_back(a);
          bq_dat.push_back(mem_word(a));
        end
      end
      if (e_rv && c_rdy) begin
        mq_addr.push_back(m_pc);
        mq_due.push_back(cyc + lat);
        m_pc = m_pc + 32'd4;
      end
      if (c_redir) begin
        bq_pc.delete(); bq_dat.delete();
        m_drop = mq_addr.size();
        m_pc = c_rpc & ~32'h3;
      end
    end
    cyc++;
  endtask

  initial begin
    bit found;
    int r;
    bit rs, st, rd, ry;
    logic [31:0] rp;

    // Reset held two cycles.
    drive(1, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 1);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    tick();

    // First two instructions with ready=1 and 1-cycle memory.
    lat = 1;
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    chk("first_ir", ir, 32'h0050_0093);
    chk("first_pc", ir_pc, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("second_ir", ir, 32'h0070_0113);
    chk("second_pc", ir_pc, 32'h4);
    tick();

    // Stall until the buffer is full, hold four cycles, then release.
    for (int i = 0; i < 10 && bq_pc.size() < DEPTH; i++) begin
      drive(0, 1, 0, 0, 1); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 1);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("stall_ir_valid", {31'b0, ir_valid}, 32'h1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1); tick();
    end

    // Latency 3 with two outstanding requests, then redirect to 0x100.
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1); tick();
      if (mq_addr.size() == 2 && mq_due[0] > cyc) break;
    end
    drive(0, 0, 1, 32'h100, 1); tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(0, 0, 0, 0, 1);
      if (ir_valid === 1'b1) begin
        found = 1'b1;
        chk("redir_first_pc", ir_pc, 32'h100);
        chk("redir_first_ir", ir, mem_word(32'h100));
      end
      tick();
    end
    chk("redir_first_seen", {31'b0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(0, 0, 0, 0, 1);
      if (ir_valid === 1'b1) begin
        found = 1'b1;
        chk("redir_second_pc", ir_pc, 32'h104);
      end
      tick();
    end
    chk("redir_second_seen", {31'b0, found}, 32'h1);

    // Misaligned redirect combined with stall while the buffer holds a word.
    lat = 1;
    for (int i = 0; i < 10 && bq_pc.size() == 0; i++) begin
      drive(0, 0, 0, 0, 1); tick();
    end
    drive(0, 1, 1, 32'h103, 1);
    chk("redir_stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("redir_align_addr", imem_req_addr, 32'h100);
    chk("redir_flush_valid", {31'b0, ir_valid}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1); tick();
    end

    // Reset mid-stream with a full buffer.
    for (int i = 0; i < 10 && bq_pc.size() < DEPTH; i++) begin
      drive(0, 1, 0, 0, 1); tick();
    end
    drive(1, 1, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    chk("midrst_ir_valid", {31'b0, ir_valid}, 32'h0);
    chk("midrst_req_addr", imem_req_addr, RESET_PC);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1); tick();
    end

    // Random traffic: ready, stall, redirect (including near address wrap), latency and reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) lat = $urandom_range(1, 4);
      r  = $urandom_range(0, 199);
      rs = (r == 0);
      rd = (r >= 1 && r < 10);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : ($urandom & 32'h0000_0FFF);
      st = ($urandom_range(0, 2) == 0);
      ry = ($urandom_range(0, 3) != 0);
      drive(rs, st, rd, rp, ry);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
